// File: rtl/pulse_rate_decoder.sv
// Tick-interval decoder: measures cycles between PulseIn ticks, recovers the 2-bit speed code and locks.
// Optional `PULSE_COUNT_EN adds TickCount, a 4-bit count of lock-keeping ticks.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no reference tick yet; counter parked at 0
//   MEASURE | timing intervals, building up MatchCnt toward LOCK_COUNT
//   LOCKED  | rate stable; SpeedOut valid, any off-rate interval unlocks
module pulse_rate_decoder #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int LOCK_COUNT      = 2
) (
  input  logic                              ClockIn,
  input  logic                              ResetN,
  input  logic                              PulseIn,
  output logic [1:0]                        SpeedOut,
  output logic                              Locked,
  output logic                              Error,
  output logic [$clog2(CLOCK_FREQUENCY):0]  Period
`ifdef PULSE_COUNT_EN
  ,
  output logic [3:0]                        TickCount
`endif
);

  localparam int W = $clog2(CLOCK_FREQUENCY) + 1;

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = W'(CLOCK_FREQUENCY + 1);
  localparam logic [W-1:0] P_TWO   = W'(2);
  localparam logic [W-1:0] P_F     = W'(CLOCK_FREQUENCY);
  localparam logic [W-1:0] P_F2    = W'(CLOCK_FREQUENCY / 2);
  localparam logic [W-1:0] P_F4    = W'(CLOCK_FREQUENCY / 4);
  localparam logic [3:0]   LOCK_TGT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [3:0]   match_cnt;
  logic [1:0]   cand;

  logic         is_match;
  logic [1:0]   code;
  logic [3:0]   match_next;

  // Exact-match classification of the interval that ends on this cycle's pulse.
  always_comb begin
    is_match = 1'b1;
    code     = 2'b00;
    if (cnt == P_TWO)
      code = 2'b00;
    else if (cnt == P_F)
      code = 2'b01;
    else if (cnt == P_F2)
      code = 2'b10;
    else if (cnt == P_F4)
      code = 2'b11;
    else
      is_match = 1'b0;
  end

  // A run only continues if the previous interval matched with the same code.
  always_comb begin
    match_next = 4'd1;
    if (match_cnt != 4'd0 && code == cand)
      match_next = match_cnt + 4'd1;
  end

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      cnt       <= '0;
      match_cnt <= 4'd0;
      cand      <= 2'b00;
      SpeedOut  <= 2'b00;
      Locked    <= 1'b0;
      Error     <= 1'b0;
      Period    <= '0;
`ifdef PULSE_COUNT_EN
      TickCount <= 4'd0;
`endif
    end else begin
      Error <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          match_cnt <= 4'd0;
          if (PulseIn) begin
            cnt   <= CNT_ONE;
            state <= MEASURE;
          end
        end

        MEASURE: begin
          if (PulseIn) begin
            cnt    <= CNT_ONE;
            Period <= cnt;
            if (is_match) begin
              match_cnt <= match_next;
              cand      <= code;
              // >= so that LOCK_COUNT=1 relocks on the interval after an unlock
              if (match_next >= LOCK_TGT) begin
                state    <= LOCKED;
                Locked   <= 1'b1;
                SpeedOut <= code;
`ifdef PULSE_COUNT_EN
                TickCount <= 4'd0;
`endif
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            Locked    <= 1'b0;
            Error     <= 1'b1;
            match_cnt <= 4'd0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LOCKED: begin
          if (PulseIn) begin
            cnt    <= CNT_ONE;
            Period <= cnt;
            if (is_match && code == SpeedOut) begin
`ifdef PULSE_COUNT_EN
              TickCount <= TickCount + 4'd1;
`endif
            end else begin
              state  <= MEASURE;
              Locked <= 1'b0;
              Error  <= 1'b1;
              if (is_match) begin
                match_cnt <= 4'd1;
                cand      <= code;
              end else begin
                match_cnt <= 4'd0;
              end
            end
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            Locked    <= 1'b0;
            Error     <= 1'b1;
            match_cnt <= 4'd0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          match_cnt <= 4'd0;
          Locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule
